fsm_mealy_ctrl: RTL
===================

// Module: fsm_mealy_ctrl
// PURPOSE
//  Parametrised Mealy-type run/error controller, successor to the basic IDLE/RUN/ERR template FSM.
//  - Adds a run-length watchdog timeout, a minimum error-hold time, and a saturating fault counter.
//  - Adds a LOCK state that only an explicit clear can release.
//  - Sits between a request/fault source and the datapath enable logic.
// PARAMETERS
//  TIMEOUT   100  RUN cycles allowed before watchdog fault (>=2)
//  ERR_HOLD  4    minimum cycles spent in ERR before exit (>=1)
//  ERR_MAX   3    fault count that forces LOCK (>=1)
//  CNT_W     8    width of run/hold counters; must hold TIMEOUT-1 and ERR_HOLD-1
// PORTS
//  clk        in   1    clock
//  rst        in   1    reset, synchronous, active-high
//  in_a       in   1    run request (level)
//  in_b       in   1    fault indication (level)
//  clr        in   1    single-cycle lock release / fault-count clear
//  out_x      out  1    active: datapath enable
//  out_y      out  1    error indication
//  timeout_o  out  1    1-cycle pulse on watchdog expiry
//  locked     out  1    high while in LOCK
//  err_cnt    out  EW   faults seen, saturating; EW=$clog2(ERR_MAX+1)
//  state_o    out  2    IDLE=0, RUN=1, ERR=2, LOCK=3
// BEHAVIOUR
//  Reset: state=IDLE; run_cnt=0; hold_cnt=0; err_cnt=0.
//  Reset values of the outputs: all 0. Reset overrides all inputs, including mid-RUN and LOCK.
//  IDLE:
//   - out_x=in_a (Mealy, same cycle).
//   - in_a -> RUN, run_cnt<=0.
//   - clr clears err_cnt.
//  RUN:
//   - out_x=1; run_cnt++ each cycle.
//   - Transition priority: in_b > timeout > !in_a.
//   - in_b: out_y=1 same cycle; -> ERR.
//   - Timeout: run_cnt==TIMEOUT-1 and !in_b; timeout_o=1 that cycle; -> ERR.
//   - !in_a -> IDLE.
//   - Entering ERR: hold_cnt<=0; err_cnt<=err_cnt+1, saturating at ERR_MAX.
//  ERR:
//   - out_y=1, out_x=0; hold_cnt++ (saturates at ERR_HOLD-1).
//   - err_cnt==ERR_MAX -> LOCK next cycle, regardless of hold.
//   - Otherwise hold done (hold_cnt==ERR_HOLD-1) and !in_b -> IDLE.
//   - Otherwise stay in ERR.
//  LOCK:
//   - out_y=1, locked=1, out_x=0; in_a and in_b are ignored.
//   - clr -> IDLE with err_cnt<=0. clr wins over a simultaneous in_b.
//  clr in RUN or ERR: no effect.
//  Timing:
//   - Latency from in_a to the RUN state: 1 cycle.
//   - Worst-case RUN duration: exactly TIMEOUT cycles.
//  Unused encodings are unreachable; the default branch -> IDLE with outputs 0.
// CONFIGURATION
//  FSM_MEALY_REG_OUT_EN defined:
//   - out_x, out_y, timeout_o and locked are registered: 1-cycle latency, glitch-free, Moore-like timing.
//   - Reset value of these outputs: 0.
//  Undefined:
//   - These outputs are combinational from state and inputs (Mealy).
//   - state_o and err_cnt are always registered.
// TESTING
//  1. Reset, then in_a=1 at cycle 0 -> out_x=1 at cycle 0, state_o=1 at cycle 1; in_a=0 -> IDLE next cycle.
//  2. In RUN, in_b=1 -> out_y=1 same cycle; ERR for exactly 4 cycles with in_b released; IDLE after; err_cnt=1.
//  3. TIMEOUT=5, in_a held -> timeout_o pulses once on the 5th RUN cycle; ERR follows; err_cnt increments.
//  4. Three faults -> err_cnt=3, LOCK; in_a and in_b ignored; clr -> IDLE, err_cnt=0.
//  5. In LOCK, clr and in_b asserted together -> IDLE. In RUN, in_b and timeout together -> one ERR entry, err_cnt +1 only.
//  6. rst asserted mid-RUN and mid-LOCK -> next cycle all outputs 0, state_o=0. Repeat with FSM_MEALY_REG_OUT_EN: outputs lag by 1 cycle.

Source files
------------

// File: rtl/fsm_mealy_ctrl.sv
// Run/error controller with watchdog, error-hold, fault counter and clear-only LOCK state.
// Latency: state_o/err_cnt 1 cycle; out_x/out_y/timeout_o/locked same cycle (1 cycle if FSM_MEALY_REG_OUT_EN).
// Backpressure: none; level inputs are sampled every cycle and never stalled.
//
// Build option FSM_MEALY_REG_OUT_EN: registers out_x, out_y, timeout_o and locked
// for glitch-free, Moore-like timing at the cost of one cycle of output latency.
module fsm_mealy_ctrl #(
   parameter int TIMEOUT  = 100,  // RUN cycles allowed before the watchdog fires (>=2)
   parameter int ERR_HOLD = 4,    // minimum cycles spent in ERR (>=1)
   parameter int ERR_MAX  = 3,    // fault count that forces LOCK (>=1)
   parameter int CNT_W    = 8,    // run/hold counter width
   localparam int EW      = $clog2(ERR_MAX + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_a,
   input  logic          in_b,
   input  logic          clr,
   output logic          out_x,
   output logic          out_y,
   output logic          timeout_o,
   output logic          locked,
   output logic [EW-1:0] err_cnt,
   output logic [1:0]    state_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      ERR  = 2'd2,
      LOCK = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(ERR_HOLD - 1);
   localparam logic [EW-1:0]    ERR_TOP   = EW'(ERR_MAX);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] run_cnt, run_cnt_nxt;
   logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
   logic [EW-1:0]    err_q, err_nxt;

   // Combinational (Mealy) output values before optional registering.
   logic x_c, y_c, t_c, l_c;

   logic run_expired;
   logic hold_done;
   logic err_full;
   logic [EW-1:0] err_inc;

   assign run_expired = (run_cnt == RUN_LAST);
   assign hold_done   = (hold_cnt == HOLD_LAST);
   assign err_full    = (err_q == ERR_TOP);
   // Fault count saturates so a stuck fault source cannot wrap it back to zero.
   assign err_inc     = err_full ? err_q : err_q + 1'b1;

   // Next-state, counter updates and Mealy outputs; priority in RUN is fault > watchdog > release.
   always_comb begin
      state_nxt    = state;
      run_cnt_nxt  = run_cnt;
      hold_cnt_nxt = hold_cnt;
      err_nxt      = err_q;
      x_c          = 1'b0;
      y_c          = 1'b0;
      t_c          = 1'b0;
      l_c          = 1'b0;

      unique case (state)
         IDLE: begin
            x_c = in_a;
            if (clr) begin
               err_nxt = '0;
            end
            if (in_a) begin
               state_nxt   = RUN;
               run_cnt_nxt = '0;
            end
         end

         RUN: begin
            x_c         = 1'b1;
            run_cnt_nxt = run_cnt + 1'b1;
            if (in_b) begin
               // A fault coinciding with watchdog expiry counts as a single ERR entry.
               y_c          = 1'b1;
               state_nxt    = ERR;
               hold_cnt_nxt = '0;
               err_nxt      = err_inc;
            end else if (run_expired) begin
               t_c          = 1'b1;
               state_nxt    = ERR;
               hold_cnt_nxt = '0;
               err_nxt      = err_inc;
            end else if (!in_a) begin
               state_nxt = IDLE;
            end
         end

         ERR: begin
            y_c = 1'b1;
            if (!hold_done) begin
               hold_cnt_nxt = hold_cnt + 1'b1;
            end
            // Reaching the fault limit locks immediately, without waiting out the hold.
            if (err_full) begin
               state_nxt = LOCK;
            end else if (hold_done && !in_b) begin
               state_nxt = IDLE;
            end
         end

         LOCK: begin
            // Run/fault inputs are ignored; only clr releases, even with in_b high.
            y_c = 1'b1;
            l_c = 1'b1;
            if (clr) begin
               state_nxt = IDLE;
               err_nxt   = '0;
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State and counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         run_cnt  <= '0;
         hold_cnt <= '0;
         err_q    <= '0;
      end else begin
         state    <= state_nxt;
         run_cnt  <= run_cnt_nxt;
         hold_cnt <= hold_cnt_nxt;
         err_q    <= err_nxt;
      end
   end

   assign state_o = state;
   assign err_cnt = err_q;

`ifdef FSM_MEALY_REG_OUT_EN
   // Registered outputs: one cycle behind the Mealy values, cleared by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_x     <= 1'b0;
         out_y     <= 1'b0;
         timeout_o <= 1'b0;
         locked    <= 1'b0;
      end else begin
         out_x     <= x_c;
         out_y     <= y_c;
         timeout_o <= t_c;
         locked    <= l_c;
      end
   end
`else
   assign out_x     = x_c;
   assign out_y     = y_c;
   assign timeout_o = t_c;
   assign locked    = l_c;
`endif

endmodule
